// File: rtl/vdf_iteration_ctrl.sv
// Sequencer for the VDF modular squaring unit: launches a job, counts squarer
// results, emits checkpoints and returns the final (or aborted) value.
module vdf_iteration_ctrl #(
    parameter int MOD_LEN = 128,
    parameter int ITER_W  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MOD_LEN-1:0] req_seed,
    input  logic [ITER_W-1:0]  req_iters,
    input  logic [ITER_W-1:0]  ckpt_interval,
    input  logic               abort,
    output logic               sqr_start,
    output logic [MOD_LEN-1:0] sqr_in,
    output logic               sqr_reset,
    input  logic [MOD_LEN-1:0] sqr_out,
    input  logic               sqr_valid,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [MOD_LEN-1:0] res_value,
    output logic [ITER_W-1:0]  res_iters_done,
    output logic               res_aborted,
    output logic               ckpt_valid,
    output logic [MOD_LEN-1:0] ckpt_value,
    output logic [ITER_W-1:0]  ckpt_iter,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [MOD_LEN-1:0] seed_q, seed_d;
    logic [ITER_W-1:0]  iters_q, iters_d;
    logic [ITER_W-1:0]  interval_q, interval_d;
    logic [ITER_W-1:0]  iterCount_q, iterCount_d;
    logic [ITER_W-1:0]  ckptCount_q, ckptCount_d;
    logic [MOD_LEN-1:0] lastValue_q, lastValue_d;
    logic               resValid_q, resValid_d;
    logic [MOD_LEN-1:0] resValue_q, resValue_d;
    logic [ITER_W-1:0]  resIters_q, resIters_d;
    logic               resAborted_q, resAborted_d;
    logic               ckptValid_q, ckptValid_d;
    logic [MOD_LEN-1:0] ckptValue_q, ckptValue_d;
    logic [ITER_W-1:0]  ckptIter_q, ckptIter_d;
    logic               sqrReset_q, sqrReset_d;

    logic [ITER_W-1:0]  nextCount;
    logic [ITER_W-1:0]  nextCkpt;

    assign nextCount = iterCount_q + 1'b1;
    assign nextCkpt  = ckptCount_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            seed_q       <= '0;
            iters_q      <= '0;
            interval_q   <= '0;
            iterCount_q  <= '0;
            ckptCount_q  <= '0;
            lastValue_q  <= '0;
            resValid_q   <= 1'b0;
            resValue_q   <= '0;
            resIters_q   <= '0;
            resAborted_q <= 1'b0;
            ckptValid_q  <= 1'b0;
            ckptValue_q  <= '0;
            ckptIter_q   <= '0;
            sqrReset_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            iters_q      <= iters_d;
            interval_q   <= interval_d;
            iterCount_q  <= iterCount_d;
            ckptCount_q  <= ckptCount_d;
            lastValue_q  <= lastValue_d;
            resValid_q   <= resValid_d;
            resValue_q   <= resValue_d;
            resIters_q   <= resIters_d;
            resAborted_q <= resAborted_d;
            ckptValid_q  <= ckptValid_d;
            ckptValue_q  <= ckptValue_d;
            ckptIter_q   <= ckptIter_d;
            sqrReset_q   <= sqrReset_d;
        end
    end

    // A separate modulo counter tracks checkpoint phase so no divider is needed.
    always_comb begin
        state_d      = state_q;
        seed_d       = seed_q;
        iters_d      = iters_q;
        interval_d   = interval_q;
        iterCount_d  = iterCount_q;
        ckptCount_d  = ckptCount_q;
        lastValue_d  = lastValue_q;
        resValid_d   = resValid_q;
        resValue_d   = resValue_q;
        resIters_d   = resIters_q;
        resAborted_d = resAborted_q;
        ckptValid_d  = 1'b0;
        ckptValue_d  = ckptValue_q;
        ckptIter_d   = ckptIter_q;
        sqrReset_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    seed_d      = req_seed;
                    iters_d     = req_iters;
                    interval_d  = ckpt_interval;
                    iterCount_d = '0;
                    ckptCount_d = '0;
                    lastValue_d = req_seed;
                    if (req_iters == '0) begin
                        state_d      = DONE;
                        resValid_d   = 1'b1;
                        resValue_d   = req_seed;
                        resIters_d   = '0;
                        resAborted_d = 1'b0;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (abort) begin
                    state_d      = DONE;
                    resValid_d   = 1'b1;
                    resValue_d   = lastValue_q;
                    resIters_d   = iterCount_q;
                    resAborted_d = 1'b1;
                    sqrReset_d   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sqr_valid) begin
                    iterCount_d = nextCount;
                    lastValue_d = sqr_out;
                    if (nextCount == iters_q) begin
                        state_d      = DONE;
                        resValid_d   = 1'b1;
                        resValue_d   = sqr_out;
                        resIters_d   = iters_q;
                        resAborted_d = 1'b0;
                        sqrReset_d   = 1'b1;
                    end else begin
                        if (interval_q != '0) begin
                            if (nextCkpt == interval_q) begin
                                ckptValid_d = 1'b1;
                                ckptValue_d = sqr_out;
                                ckptIter_d  = nextCount;
                                ckptCount_d = '0;
                            end else begin
                                ckptCount_d = nextCkpt;
                            end
                        end
                        if (abort) begin
                            state_d      = DONE;
                            resValid_d   = 1'b1;
                            resValue_d   = sqr_out;
                            resIters_d   = nextCount;
                            resAborted_d = 1'b1;
                            sqrReset_d   = 1'b1;
                        end
                    end
                end else if (abort) begin
                    state_d      = DONE;
                    resValid_d   = 1'b1;
                    resValue_d   = lastValue_q;
                    resIters_d   = iterCount_q;
                    resAborted_d = 1'b1;
                    sqrReset_d   = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d    = IDLE;
                    resValid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The squarer is held in reset for the whole of a controller reset.
    assign sqr_reset      = reset | sqrReset_q;
    assign req_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign sqr_start      = (state_q == LAUNCH);
    assign sqr_in         = sqr_start ? seed_q : '0;
    assign res_valid      = resValid_q;
    assign res_value      = resValue_q;
    assign res_iters_done = resIters_q;
    assign res_aborted    = resAborted_q;
    assign ckpt_valid     = ckptValid_q;
    assign ckpt_value     = ckptValue_q;
    assign ckpt_iter      = ckptIter_q;

endmodule

// File: tb/tb_vdf_iteration_ctrl.sv
// Directed bench for vdf_iteration_ctrl: a behavioural squarer (mod 2^127-1)
// drives table jobs; hand-driven sqr_valid pulses cover abort/reset corners.
module tb_vdf_iteration_ctrl;

    localparam int MOD_LEN = 128;
    localparam int ITER_W  = 64;
    localparam int LAT     = 3;
    localparam logic [MOD_LEN-1:0] MODULUS = {1'b0, {127{1'b1}}};

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [MOD_LEN-1:0] req_seed;
    logic [ITER_W-1:0]  req_iters;
    logic [ITER_W-1:0]  ckpt_interval;
    logic               abort;
    logic               sqr_start;
    logic [MOD_LEN-1:0] sqr_in;
    logic               sqr_reset;
    logic [MOD_LEN-1:0] sqr_out;
    logic               sqr_valid;
    logic               res_valid;
    logic               res_ready;
    logic [MOD_LEN-1:0] res_value;
    logic [ITER_W-1:0]  res_iters_done;
    logic               res_aborted;
    logic               ckpt_valid;
    logic [MOD_LEN-1:0] ckpt_value;
    logic [ITER_W-1:0]  ckpt_iter;
    logic               busy;

    int vecCount  = 0;
    int missCount = 0;

    vdf_iteration_ctrl #(.MOD_LEN(MOD_LEN), .ITER_W(ITER_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_seed(req_seed),
        .req_iters(req_iters), .ckpt_interval(ckpt_interval), .abort(abort),
        .sqr_start(sqr_start), .sqr_in(sqr_in), .sqr_reset(sqr_reset),
        .sqr_out(sqr_out), .sqr_valid(sqr_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
        .res_iters_done(res_iters_done), .res_aborted(res_aborted),
        .ckpt_valid(ckpt_valid), .ckpt_value(ckpt_value), .ckpt_iter(ckpt_iter),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Free-running squarer model: one result every LAT cycles until sqr_reset.
    logic               useModel = 1'b1;
    logic               manValid = 1'b0;
    logic [MOD_LEN-1:0] manOut   = '0;
    logic               mValid   = 1'b0;
    logic               mActive  = 1'b0;
    logic [MOD_LEN-1:0] mOut     = '0;
    logic [MOD_LEN-1:0] mVal     = '0;
    logic [MOD_LEN-1:0] mSq;
    logic [2*MOD_LEN-1:0] mWide;
    int                 mCnt     = 0;

    always_comb begin
        mWide = ({{MOD_LEN{1'b0}}, mVal} * {{MOD_LEN{1'b0}}, mVal}) % {{MOD_LEN{1'b0}}, MODULUS};
        mSq   = mWide[MOD_LEN-1:0];
    end

    always @(posedge clk) begin
        mValid <= 1'b0;
        if (sqr_reset) begin
            mActive <= 1'b0;
            mCnt    <= 0;
        end else if (sqr_start) begin
            mActive <= 1'b1;
            mVal    <= sqr_in;
            mCnt    <= 0;
        end else if (mActive) begin
            if (mCnt == LAT - 1) begin
                mCnt   <= 0;
                mValid <= 1'b1;
                mOut   <= mSq;
                mVal   <= mSq;
            end else begin
                mCnt <= mCnt + 1;
            end
        end
    end

    assign sqr_valid = useModel ? mValid : manValid;
    assign sqr_out   = useModel ? mOut : manOut;

    int                 startCount = 0;
    int                 resetCount = 0;
    logic [ITER_W-1:0]  ckptIterQ[$];
    logic [MOD_LEN-1:0] ckptValQ[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (sqr_start) startCount++;
            if (sqr_reset) resetCount++;
            if (ckpt_valid) begin
                ckptIterQ.push_back(ckpt_iter);
                ckptValQ.push_back(ckpt_value);
            end
        end
    end

    typedef struct {
        logic [MOD_LEN-1:0] seed;
        logic [ITER_W-1:0]  iters;
        logic [ITER_W-1:0]  interval;
        logic [MOD_LEN-1:0] expValue;
        int                 expCkpts;
        logic [ITER_W-1:0]  ck1Iter;
        logic [MOD_LEN-1:0] ck1Val;
        logic [ITER_W-1:0]  ck2Iter;
        logic [MOD_LEN-1:0] ck2Val;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [MOD_LEN-1:0] actual,
                               input logic [MOD_LEN-1:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic acceptJob(input logic [MOD_LEN-1:0] seed, input logic [ITER_W-1:0] iters,
                             input logic [ITER_W-1:0] interval);
        req_valid     = 1'b1;
        req_seed      = seed;
        req_iters     = iters;
        ckpt_interval = interval;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse(input logic [MOD_LEN-1:0] value);
        manValid = 1'b1;
        manOut   = value;
        tick();
        manValid = 1'b0;
        manOut   = '0;
        tick();
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int s0 = startCount;
        int r0 = resetCount;
        int q0 = ckptIterQ.size();
        int waited;
        int expPulses;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        checkOutput("req_ready_before_job", req_ready, 1);
        acceptJob(v.seed, v.iters, v.interval);
        waited = 1;
        while (!res_valid && waited < 500) begin
            tick();
            waited++;
        end
        checkOutput("res_valid", res_valid, 1);
        checkOutput("res_value", res_value, v.expValue);
        checkOutput("res_iters_done", res_iters_done, v.iters);
        checkOutput("res_aborted", res_aborted, 0);
        if (v.iters == '0) checkOutput("t0_latency_ok", waited <= 2, 1);
        handshake();
        checkOutput("res_valid_cleared", res_valid, 0);
        expPulses = (v.iters == '0) ? 0 : 1;
        checkOutput("sqr_start_pulses", startCount - s0, expPulses);
        checkOutput("sqr_reset_pulses", resetCount - r0, expPulses);
        checkOutput("ckpt_count", ckptIterQ.size() - q0, v.expCkpts);
        if (v.expCkpts >= 1 && ckptIterQ.size() - q0 >= 1) begin
            checkOutput("ckpt1_iter", ckptIterQ[q0], v.ck1Iter);
            checkOutput("ckpt1_value", ckptValQ[q0], v.ck1Val);
        end
        if (v.expCkpts >= 2 && ckptIterQ.size() - q0 >= 2) begin
            checkOutput("ckpt2_iter", ckptIterQ[q0+1], v.ck2Iter);
            checkOutput("ckpt2_value", ckptValQ[q0+1], v.ck2Val);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bad;
        vecs[0] = '{128'd3, 64'd2, 64'd0, 128'd81, 0, 64'd0, 128'd0, 64'd0, 128'd0};
        vecs[1] = '{128'd2, 64'd5, 64'd2, 128'h1_0000_0000, 2, 64'd2, 128'd16, 64'd4, 128'd65536};
        vecs[2] = '{128'd5, 64'd0, 64'd0, 128'd5, 0, 64'd0, 128'd0, 64'd0, 128'd0};
        vecs[3] = '{128'd2, 64'd7, 64'd3, 128'd2, 2, 64'd3, 128'd256, 64'd6, 128'h1_0000_0000_0000_0000};
        vecs[4] = '{128'd7, 64'd1, 64'd1, 128'd49, 0, 64'd0, 128'd0, 64'd0, 128'd0};
        vecs[5] = '{128'd3, 64'd3, 64'd3, 128'd6561, 0, 64'd0, 128'd0, 64'd0, 128'd0};

        reset = 1'b1; req_valid = 1'b0; req_seed = '0; req_iters = '0;
        ckpt_interval = '0; abort = 1'b0; res_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_sqr_reset", sqr_reset, 1);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sqr_start", sqr_start, 0);
        checkOutput("rst_sqr_in", sqr_in, 0);
        checkOutput("rst_ckpt_valid", ckpt_valid, 0);
        checkOutput("rst_res_value", res_value, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Abort one cycle after the third squaring of a long job.
        useModel = 1'b0;
        acceptJob(128'd2, 64'd100, 64'd0);
        checkOutput("launch_sqr_start", sqr_start, 1);
        checkOutput("launch_sqr_in", sqr_in, 2);
        checkOutput("launch_busy", busy, 1);
        tick();
        checkOutput("run_sqr_in_zero", sqr_in, 0);
        pulse(128'd4);
        pulse(128'd16);
        pulse(128'd256);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_res_valid", res_valid, 1);
        checkOutput("abort_res_value", res_value, 256);
        checkOutput("abort_res_iters", res_iters_done, 3);
        checkOutput("abort_res_aborted", res_aborted, 1);
        checkOutput("abort_sqr_reset", sqr_reset, 1);
        handshake();

        // Abort coinciding with the final squaring: completion wins.
        acceptJob(128'd2, 64'd3, 64'd0);
        tick();
        pulse(128'd4);
        pulse(128'd16);
        manValid = 1'b1; manOut = 128'd256; abort = 1'b1;
        tick();
        manValid = 1'b0; manOut = '0; abort = 1'b0;
        checkOutput("final_abort_res_valid", res_valid, 1);
        checkOutput("final_abort_aborted", res_aborted, 0);
        checkOutput("final_abort_value", res_value, 256);
        checkOutput("final_abort_iters", res_iters_done, 3);
        handshake();

        // Abort during LAUNCH returns the seed with zero iterations.
        acceptJob(128'd9, 64'd10, 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("launch_abort_value", res_value, 9);
        checkOutput("launch_abort_iters", res_iters_done, 0);
        checkOutput("launch_abort_aborted", res_aborted, 1);
        checkOutput("launch_abort_sqr_reset", sqr_reset, 1);
        handshake();

        // Result backpressure with a pending request and stray sqr_valid.
        acceptJob(128'd3, 64'd1, 64'd0);
        tick();
        pulse(128'd9);
        req_valid = 1'b1; req_seed = 128'd5; req_iters = 64'd0; ckpt_interval = '0;
        manValid = 1'b1; manOut = 128'd123;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(res_valid === 1'b1 && res_value === 128'd9 && res_iters_done === 64'd1 &&
                  req_ready === 1'b0 && busy === 1'b1))
                bad++;
        end
        manValid = 1'b0; manOut = '0;
        checkOutput("hold_unstable_cycles", bad, 0);
        handshake();
        checkOutput("post_handshake_req_ready", req_ready, 1);
        checkOutput("post_handshake_res_valid", res_valid, 0);
        tick();
        req_valid = 1'b0;
        checkOutput("pending_accepted_res_valid", res_valid, 1);
        checkOutput("pending_accepted_value", res_value, 5);
        handshake();

        // Reset mid-job after one squaring, then a fresh job.
        acceptJob(128'd2, 64'd5, 64'd0);
        tick();
        pulse(128'd4);
        reset = 1'b1;
        tick();
        checkOutput("midrst_req_ready", req_ready, 1);
        checkOutput("midrst_res_valid", res_valid, 0);
        checkOutput("midrst_sqr_reset", sqr_reset, 1);
        checkOutput("midrst_busy", busy, 0);
        reset = 1'b0;
        useModel = 1'b1;
        tick();
        applyStimulus('{128'd2, 64'd1, 64'd0, 128'd4, 0, 64'd0, 128'd0, 64'd0, 128'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
